// File: rtl/pipeline_credit_pkg.sv
// rtl/pipeline_credit_pkg.sv - shared widths helper and error-cause encoding for the credit FIFO
package pipeline_credit_pkg;

    // Reason the sticky error flag is being raised in a given cycle.
    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_OVERFLOW,
        ERR_SPURIOUS,
        ERR_LATENCY
    } err_cause_t;

    // Bits needed to index 0..value-1, never less than one bit.
    function automatic int clog2_depth(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/credit_fifo_mem.sv
// rtl/credit_fifo_mem.sv - result storage, one write port and one asynchronous read port
module credit_fifo_mem
    import pipeline_credit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = clog2_depth(DEPTH)
) (
    input  logic             clock,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    input  logic [WIDTH-1:0] write_data,
    input  logic [AW-1:0]    read_addr,
    output logic [WIDTH-1:0] read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Data array carries no reset; validity is tracked by the controller's count.
    always_ff @(posedge clock) begin
        if (write_enable) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data = mem[read_addr];

endmodule

// File: rtl/pipeline_credit_fifo.sv
// rtl/pipeline_credit_fifo.sv - credit-gated issue into a fixed-latency pipe with FWFT result FIFO (option: PIPELINE_CREDIT_LATENCY_CHECK_EN)
module pipeline_credit_fifo
    import pipeline_credit_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             pipe_in_valid,
    output logic [WIDTH-1:0] pipe_in_data,
    input  logic             pipe_out_valid,
    input  logic [WIDTH-1:0] pipe_out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             error
);

    localparam int AW = clog2_depth(DEPTH);
    localparam int CW = clog2_depth(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] in_flight;
    logic [CW:0]   reserved;
    logic          fire_in;
    logic          fire_out;
    logic          enq;
    logic          overflow;
    logic          spurious;
    logic          latency_fault;
    err_cause_t    cause;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
        return (ptr == LAST_C) ? '0 : ptr + AW'(1);
    endfunction

    // Every slot is either holding a result or promised to a beat still in the pipe.
    assign reserved      = {1'b0, count} + {1'b0, in_flight};
    assign in_ready      = !reset && (reserved < {1'b0, DEPTH_C});
    assign fire_in       = in_valid & in_ready;
    assign pipe_in_valid = fire_in;
    assign pipe_in_data  = in_data;

    assign out_valid = !reset && (count != '0);
    assign fire_out  = out_valid & out_ready;

    // A result arriving at a full FIFO with no same-cycle dequeue is lost.
    assign overflow = pipe_out_valid && (count == DEPTH_C) && !fire_out;
    assign enq      = pipe_out_valid && !overflow;
    assign spurious = pipe_out_valid && (in_flight == '0);

`ifdef PIPELINE_CREDIT_LATENCY_CHECK_EN
    logic [LATENCY-1:0] shadow_valid;

    // Shadow of the pipe's valid chain: where a result must appear if the pipe honours LATENCY.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_valid <= '0;
        end else begin
            shadow_valid[0] <= fire_in;
            for (int i = 1; i < LATENCY; i++) begin
                shadow_valid[i] <= shadow_valid[i-1];
            end
        end
    end

    assign latency_fault = pipe_out_valid != shadow_valid[LATENCY-1];
`else
    assign latency_fault = 1'b0;
`endif

    // Pointers, occupancy and outstanding-issue bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            in_flight <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (fire_out) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({enq, fire_out})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            case ({fire_in, pipe_out_valid})
                2'b10:   in_flight <= in_flight + CW'(1);
                2'b01:   in_flight <= (in_flight != '0) ? in_flight - CW'(1) : '0;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            error <= 1'b0;
        end else if (overflow || spurious || latency_fault) begin
            error <= 1'b1;
        end
    end

    // Classify the cycle's fault for the consistency assertion below.
    always_comb begin
        cause = ERR_NONE;
        if (overflow) begin
            cause = ERR_OVERFLOW;
        end else if (spurious) begin
            cause = ERR_SPURIOUS;
        end else if (latency_fault) begin
            cause = ERR_LATENCY;
        end
    end

    // error may only rise in a cycle that has a recognised cause.
    assert property (@(posedge clock) disable iff (reset)
        (!error && cause == ERR_NONE) |=> !error);

    // Parameter sanity.
    assert property (@(posedge clock) (LATENCY >= 1) && (DEPTH >= 1));

    credit_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock        (clock),
        .write_enable (enq),
        .write_addr   (wr_ptr),
        .write_data   (pipe_out_data),
        .read_addr    (rd_ptr),
        .read_data    (out_data)
    );

endmodule

// File: tb/tb_pipeline_credit_fifo.sv
// tb/tb_pipeline_credit_fifo.sv - self-checking bench: reference pipe, queue model, directed and random traffic
module tb_pipeline_credit_fifo;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready;
    logic             pipe_in_valid;
    logic [WIDTH-1:0] pipe_in_data;
    logic             pipe_out_valid;
    logic [WIDTH-1:0] pipe_out_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             error;

    logic             force_en = 1'b0;
    logic             force_valid = 1'b0;
    logic [WIDTH-1:0] force_data = '0;
    logic             pv [LATENCY];
    logic [WIDTH-1:0] pd [LATENCY];

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [$];
    int               arrivals [$];
    int               m_inflight = 0;
    bit               m_err = 1'b0;
    int               cyc = 0;

    logic             s_ir;
    logic             s_ov;
    logic [WIDTH-1:0] s_od;
    logic             s_err;

    typedef struct {
        bit               rst;
        bit               iv;
        logic [WIDTH-1:0] d;
        bit               ordy;
        bit               exp_ov;
        logic [WIDTH-1:0] exp_od;
    } vec_t;
    vec_t vt [8];

    always #5 clock = ~clock;

    pipeline_credit_fifo #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .pipe_in_valid  (pipe_in_valid),
        .pipe_in_data   (pipe_in_data),
        .pipe_out_valid (pipe_out_valid),
        .pipe_out_data  (pipe_out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .error          (error)
    );

    // External PipelineRegister with STAGES=LATENCY, sharing the DUT reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) pv[i] <= 1'b0;
        end else begin
            pv[0] <= pipe_in_valid;
            pd[0] <= pipe_in_data;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign pipe_out_valid = force_en ? force_valid : pv[LATENCY-1];
    assign pipe_out_data  = force_en ? force_data  : pd[LATENCY-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: compare DUT against the queue model at negedge, then advance the model.
    task automatic step();
        bit exp_ir;
        bit exp_ov;
        bit fin;
        bit fout;
        bit pov;
        bit expect_pov;
        int nf;
        logic [WIDTH-1:0] pdat;
        @(negedge clock);
        exp_ir = !reset && ((mq.size() + m_inflight) < DEPTH);
        exp_ov = !reset && (mq.size() != 0);
        s_ir = in_ready;
        s_ov = out_valid;
        s_od = out_data;
        s_err = error;
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov) check("out_data", 32'(out_data), 32'(mq[0]));
        check("error", 32'(error), 32'(m_err));
        check("pipe_in_valid", 32'(pipe_in_valid), 32'(in_valid && exp_ir));
        if (in_valid && exp_ir) check("pipe_in_data", 32'(pipe_in_data), 32'(in_data));
        fin = in_valid && exp_ir;
        fout = exp_ov && out_ready;
        pov = pipe_out_valid;
        pdat = pipe_out_data;
        if (reset) begin
            mq.delete();
            arrivals.delete();
            m_inflight = 0;
            m_err = 1'b0;
        end else begin
`ifdef PIPELINE_CREDIT_LATENCY_CHECK_EN
            expect_pov = (arrivals.size() != 0) && (arrivals[0] == cyc);
            if (pov != expect_pov) m_err = 1'b1;
`else
            expect_pov = (arrivals.size() != 0) && (arrivals[0] == cyc);
`endif
            if (expect_pov) void'(arrivals.pop_front());
            if (fin) arrivals.push_back(cyc + LATENCY);
            if (pov && m_inflight == 0) m_err = 1'b1;
            nf = m_inflight + int'(fin) - int'(pov);
            m_inflight = (nf < 0) ? 0 : nf;
            if (fout) void'(mq.pop_front());
            if (pov) begin
                if (mq.size() < DEPTH) mq.push_back(pdat);
                else m_err = 1'b1;
            end
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        force_en = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Offer beats base, base+1, ... with out_ready low until DEPTH are accepted.
    task automatic fill(input logic [WIDTH-1:0] base, output int acc);
        acc = 0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = base + WIDTH'(acc);
            step();
            if (s_ir) acc++;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int acc;
        int seen;
        logic [WIDTH-1:0] got [$];

        vt[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vt[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00};
        vt[2] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 8'h00};
        vt[3] = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 8'h00};
        vt[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11};
        vt[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22};
        vt[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33};
        vt[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};

        // Test 1: three beats stream through with LATENCY+1 cycles to the output.
        for (int i = 0; i < 8; i++) begin
            reset = vt[i].rst;
            in_valid = vt[i].iv;
            in_data = vt[i].d;
            out_ready = vt[i].ordy;
            step();
            check($sformatf("t1_out_valid[%0d]", i), 32'(s_ov), 32'(vt[i].exp_ov));
            if (vt[i].exp_ov) check($sformatf("t1_out_data[%0d]", i), 32'(s_od), 32'(vt[i].exp_od));
        end
        reset = 1'b0;
        check("t1_error", 32'(s_err), 32'(0));

        // Test 2: backpressure accepts exactly DEPTH beats; credit returns one cycle after dequeue.
        do_reset();
        fill(8'h40, acc);
        check("t2_accepted", 32'(acc), 32'(DEPTH));
        check("t2_in_ready_low", 32'(s_ir), 32'(0));
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            step();
            check("t2_out_valid", 32'(s_ov), 32'(1));
            check("t2_out_data", 32'(s_od), 32'(8'h40 + k));
            if (k == 0) check("t2_in_ready_same", 32'(s_ir), 32'(0));
            if (k == 1) check("t2_in_ready_next", 32'(s_ir), 32'(1));
        end
        step();
        check("t2_drained", 32'(s_ov), 32'(0));

        // Test 3: full FIFO, forced result plus dequeue in one cycle; pointers wrap 3->0.
        fill(8'h50, acc);
        check("t3_accepted", 32'(acc), 32'(DEPTH));
        force_en = 1'b1;
        force_valid = 1'b1;
        force_data = 8'hA5;
        out_ready = 1'b1;
        step();
        check("t3_head", 32'(s_od), 32'(8'h50));
        force_en = 1'b0;
        step();
        check("t3_still_full", 32'(s_ir), 32'(0));
        got.delete();
        got.push_back(s_od);
        for (int k = 0; k < 5; k++) begin
            step();
            if (s_ov) got.push_back(s_od);
        end
        check("t3_count", 32'(got.size()), 32'(4));
        if (got.size() == 4) begin
            check("t3_order0", 32'(got[0]), 32'(8'h51));
            check("t3_order3", 32'(got[3]), 32'(8'hA5));
        end

        // Test 4: spurious result into a full FIFO is dropped and error sticks until reset.
        do_reset();
        fill(8'h60, acc);
        force_en = 1'b1;
        force_valid = 1'b1;
        force_data = 8'hEE;
        step();
        force_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_error_sticky", 32'(s_err), 32'(1));
        end
        out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_ov) got.push_back(s_od);
        end
        check("t4_kept", 32'(got.size()), 32'(DEPTH));
        if (got.size() == DEPTH) check("t4_last", 32'(got[DEPTH-1]), 32'(8'h63));
        do_reset();
        step();
        check("t4_error_cleared", 32'(s_err), 32'(0));

        // Test 5: reset with beats both queued and in flight discards all of them.
        do_reset();
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'h70 + 8'(k);
            step();
        end
        do_reset();
        step();
        check("t5_out_valid", 32'(s_ov), 32'(0));
        check("t5_in_ready", 32'(s_ir), 32'(1));
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_ov) seen++;
        end
        check("t5_no_stale", 32'(seen), 32'(0));

        // Test 6: one result returned a cycle late.
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h99;
        step();
        in_valid = 1'b0;
        force_en = 1'b1;
        force_valid = 1'b0;
        step();
        step();
        force_valid = 1'b1;
        force_data = 8'h99;
        step();
        force_en = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (s_ov && s_od == 8'h99) seen++;
        end
        check("t6_delivered", 32'(seen), 32'(1));
`ifdef PIPELINE_CREDIT_LATENCY_CHECK_EN
        check("t6_error", 32'(s_err), 32'(1));
`else
        check("t6_error", 32'(s_err), 32'(0));
`endif

        // Random traffic against the queue model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data = WIDTH'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        check("rand_error", 32'(s_err), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
